// File: rtl/vga_stream_out.sv
// vga_stream_out: pixel FIFO, frame-lock FSM and programmable VGA timing.
// Define VGA_STREAM_TEST_PATTERN_EN to fill unlocked pixels with colour bars.
module vga_stream_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_POL   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3*COLOR_W-1:0] in_data,
  input  logic                 in_sop,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 frame_locked,
  output logic [15:0]          underflow_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 3 * COLOR_W;
  localparam logic POL = (SYNC_POL != 0);

  typedef enum logic [1:0] {SEEK, WAIT, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [31:0]   h_x, v_x;
  logic          active, at_org, h_sync, v_sync;

  logic [PW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          rdy_q, empty, full, push, pop;
  logic          head_sop;
  logic [PW-1:0] head_px;

  logic          show, uf_inc;
  logic [PW-1:0] fill, px_d, px_q;
  logic          hs_q, vs_q, blank_q;
  logic [15:0]   uf_q;

  assign h_x    = 32'(h_cnt_q);
  assign v_x    = 32'(v_cnt_q);
  assign active = (h_x < H_ACTIVE) && (v_x < V_ACTIVE);
  assign at_org = (h_x == 0) && (v_x == 0);
  assign h_sync = (h_x >= H_ACTIVE + H_FP) &&
                  (h_x < H_ACTIVE + H_FP + H_SYNC);
  assign v_sync = (v_x >= V_ACTIVE + V_FP) &&
                  (v_x < V_ACTIVE + V_FP + V_SYNC);

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_x == H_TOTAL - 1) begin
      h_cnt_d = '0;
      v_cnt_d = (v_x == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
    end
  end

  assign {head_sop, head_px} = mem_q[rd_q[AW-1:0]];
  assign empty    = (wr_q == rd_q);
  assign full     = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign in_ready = rdy_q & ~full;
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= {in_sop, in_data};
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    show    = 1'b0;
    uf_inc  = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (!empty) begin
          if (head_sop) state_d = WAIT;
          else          pop     = 1'b1;
        end
      end
      WAIT: begin
        if (at_org && !empty) begin
          pop     = 1'b1;
          show    = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (active) begin
          if (empty) begin
            uf_inc  = 1'b1;
            state_d = SEEK;
          end else if (head_sop && !at_org) begin
            state_d = WAIT;
          end else if (!head_sop && at_org) begin
            state_d = SEEK;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

`ifdef VGA_STREAM_TEST_PATTERN_EN
  logic [2:0] bar, bits;
  assign bar = 3'(h_x * 8 / H_ACTIVE);
  // bits are {R,G,B} on/off for each bar, left to right
  always_comb begin
    bits = 3'b000;
    unique case (bar)
      3'd0: bits = 3'b111;
      3'd1: bits = 3'b110;
      3'd2: bits = 3'b011;
      3'd3: bits = 3'b010;
      3'd4: bits = 3'b101;
      3'd5: bits = 3'b100;
      3'd6: bits = 3'b001;
      3'd7: bits = 3'b000;
    endcase
  end
  assign fill = {{COLOR_W{bits[2]}}, {COLOR_W{bits[1]}},
                 {COLOR_W{bits[0]}}};
`else
  assign fill = '0;
`endif

  assign px_d = !active ? '0 : (show ? head_px : fill);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEEK;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      px_q    <= '0;
      hs_q    <= ~POL;
      vs_q    <= ~POL;
      blank_q <= 1'b0;
      uf_q    <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      rdy_q   <= 1'b1;
      px_q    <= px_d;
      hs_q    <= h_sync ? POL : ~POL;
      vs_q    <= v_sync ? POL : ~POL;
      blank_q <= active;
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      if (uf_inc && uf_q != 16'hFFFF) uf_q <= uf_q + 16'd1;
    end
  end

  assign {vga_r, vga_g, vga_b} = px_q;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_blank_n   = blank_q;
  assign vga_sync_n    = 1'b0;
  assign frame_locked  = (state_q == LOCKED);
  assign underflow_cnt = uf_q;
endmodule
